// File: rtl/stack_pkg.sv
// Shared definitions for the stack port arbiter: op width, requester limits and FSM states.
package stack_pkg;
    localparam int OP_W    = 4;
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of (req & mask) at or after ptr, wrapping at N.
module rr_pick
    import stack_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] index,
    output logic             any
);
    logic [N-1:0]   cand;
    logic [IDX_W:0] pos;

    assign cand = req & mask;

    always_comb begin
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        pos    = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (pos >= (IDX_W + 1)'(N)) pos = pos - (IDX_W + 1)'(N);
            for (int j = 0; j < N; j++) begin
                if (!any && cand[j] && pos == (IDX_W + 1)'(j)) begin
                    onehot[j] = 1'b1;
                    index     = IDX_W'(j);
                    any       = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/stack_port_arbiter.sv
// Shares one hardware stack between N requesters: round-robin grant per command, optional
// lock across multi-op sequences, single-cycle apply, bounded wait for the stack's valid.
module stack_port_arbiter
    import stack_pkg::*;
#(
    parameter int W       = 16,
    parameter int N       = 2,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [N-1:0]      lock,
    input  logic [OP_W*N-1:0] op_bus,
    input  logic [W*N-1:0]    data_bus,
    output logic [N-1:0]      done,
    output logic [N-1:0]      err,
    output logic [W-1:0]      rdata,
    output logic [IDX_W-1:0]  owner,
    output logic              busy,
    output logic [OP_W-1:0]   stk_op,
    output logic [W-1:0]      stk_in,
    output logic              stk_apply,
    input  logic [W-1:0]      stk_head,
    input  logic              stk_empty,
    input  logic              stk_valid,
    output logic              empty,
    output state_t            dbg_state
);
    // Requester handshake: req[i] stays high until done[i]; a command is taken when granted in
    // IDLE, its op/data are sampled once at grant, and done[i] (with err[i] on timeout) is a
    // single-cycle pulse carrying rdata. Dropping req after grant does not cancel the command.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state, state_nxt;
    logic [N-1:0]      mask, pick_onehot, owner_onehot;
    logic [IDX_W-1:0]  pick_idx, rr_ptr;
    logic              pick_any, locked, lock_owner, hold;
    logic [CNT_W-1:0]  wait_cnt;
    logic              grant, finish_ok, finish_to;
    logic [OP_W-1:0]   op_sel;
    logic [W-1:0]      data_sel;

    assign empty     = stk_empty;
    assign dbg_state = state;

    always_comb begin
        owner_onehot = '0;
        for (int i = 0; i < N; i++)
            if (owner == IDX_W'(i)) owner_onehot[i] = 1'b1;
    end

    // While the lock holds, only the owner competes; a dropped lock frees the grant this cycle.
    assign lock_owner = |(lock & owner_onehot);
    assign hold       = locked && lock_owner;
    assign mask       = hold ? owner_onehot : '1;

    rr_pick #(.N(N)) u_pick (
        .req    (req),
        .mask   (mask),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .index  (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        op_sel   = '0;
        data_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                op_sel   = op_bus[i*OP_W +: OP_W];
                data_sel = data_bus[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stk_apply = 1'b0;
        busy      = 1'b0;
        grant     = 1'b0;
        finish_ok = 1'b0;
        finish_to = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_any) begin
                    grant     = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                stk_apply = 1'b1;
                busy      = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (stk_valid) begin
                    finish_ok = 1'b1;
                    state_nxt = S_IDLE;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    finish_to = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done     <= '0;
            err      <= '0;
            rdata    <= '0;
            owner    <= '0;
            stk_op   <= '0;
            stk_in   <= '0;
            rr_ptr   <= '0;
            locked   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            done <= '0;
            err  <= '0;
            if (grant) begin
                stk_op <= op_sel;
                stk_in <= data_sel;
                owner  <= pick_idx;
            end
            if (state == S_IDLE && locked && !lock_owner) locked <= 1'b0;
            if (state == S_ISSUE)     wait_cnt <= '0;
            else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
            if (finish_ok || finish_to) begin
                done   <= owner_onehot;
                err    <= finish_to ? owner_onehot : '0;
                rdata  <= finish_ok ? stk_head : '0;
                locked <= lock_owner;
                if (!lock_owner)
                    rr_ptr <= (owner == IDX_W'(N - 1)) ? '0 : owner + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stack_port_arbiter.sv
// Self-checking bench for stack_port_arbiter: scripted requesters, a delay-programmable stack
// responder, and a scoreboard queue of expected {err, owner, rdata} completions.
module tb_stack_port_arbiter;
    import stack_pkg::*;

    localparam int W = 16;
    localparam int N = 2;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N-1:0]      lock = '0;
    logic [OP_W*N-1:0] op_bus = '0;
    logic [W*N-1:0]    data_bus = '0;
    logic [N-1:0]      done, err;
    logic [W-1:0]      rdata;
    logic [IDX_W-1:0]  owner;
    logic              busy, stk_apply, empty;
    logic [OP_W-1:0]   stk_op;
    logic [W-1:0]      stk_in;
    logic [W-1:0]      stk_head;
    logic              stk_empty = 1'b0;
    logic              stk_valid;
    state_t            dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [W+3:0] exp_q[$];

    // Stack responder: raise stk_valid resp_dly cycles after an apply (0 = never).
    int           resp_dly = 0;
    logic [W-1:0] resp_head = '0;
    int           cd = 0;
    logic         apply_seen = 1'b0;
    int           m_ptr = 0;

    stack_port_arbiter #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .op_bus    (op_bus),
        .data_bus  (data_bus),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .owner     (owner),
        .busy      (busy),
        .stk_op    (stk_op),
        .stk_in    (stk_in),
        .stk_apply (stk_apply),
        .stk_head  (stk_head),
        .stk_empty (stk_empty),
        .stk_valid (stk_valid),
        .empty     (empty),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) apply_seen <= stk_apply & rst;

    always @(posedge clk) begin
        #1;
        stk_valid = 1'b0;
        if (!rst) begin
            cd       = 0;
            stk_head = '0;
        end else begin
            if (apply_seen) cd = resp_dly;
            if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) begin
                    stk_valid = 1'b1;
                    stk_head  = resp_head;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_apply(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            if (stk_apply) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            if (done != '0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        next_cycle();
        next_cycle();
        checks++;
        if ({done, err, rdata, owner, stk_op, stk_in, stk_apply, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {done, err, rdata, owner, stk_op, stk_in, stk_apply, busy});
        end
        checks++;
        if (dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE);
        end
        stk_empty = 1'b1;
        #1;
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL empty_pass_hi got=%b exp=1", empty);
        end
        stk_empty = 1'b0;
        #1;
        checks++;
        if (empty !== 1'b0) begin
            errors++;
            $display("FAIL empty_pass_lo got=%b exp=0", empty);
        end
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_single();
        logic [W+3:0] e;
        resp_dly  = 1;
        resp_head = 16'h1234;
        op_bus    = {4'h0, 4'h7};
        data_bus  = {16'd0, 16'd150};
        req       = 2'b01;
        exp_q.push_back({1'b0, 3'd0, 16'h1234});
        next_cycle();
        checks++;
        if ({stk_apply, stk_op, stk_in, owner} !== {1'b1, 4'h7, 16'd150, 3'd0}) begin
            errors++;
            $display("FAIL single_issue got apply=%b op=%h in=%0d owner=%0d exp 1 7 150 0",
                     stk_apply, stk_op, stk_in, owner);
        end
        next_cycle();
        checks++;
        if ({stk_apply, busy} !== 2'b01) begin
            errors++;
            $display("FAIL single_wait got apply=%b busy=%b exp 0 1", stk_apply, busy);
        end
        next_cycle();
        req = 2'b00;
        e = exp_q.pop_front();
        checks++;
        if (done !== 2'b01 || {|err, owner, rdata} !== e) begin
            errors++;
            $display("FAIL single_done got done=%b res=%h exp done=01 res=%h",
                     done, {|err, owner, rdata}, e);
        end
        next_cycle();
        checks++;
        if (done !== 2'b00 || rdata !== 16'h1234) begin
            errors++;
            $display("FAIL single_hold got done=%b rdata=%h exp 00 1234", done, rdata);
        end
        m_ptr = 1;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int last_apply;
        logic [2:0] exp_owner;
        logic [W-1:0] head;
        logic [W+3:0] e;
        last_apply = 0;
        resp_dly = 1;
        op_bus   = {4'h5, 4'h3};
        data_bus = {16'd200, 16'd100};
        req      = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_owner = 3'(m_ptr);
            wait_apply(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL b2b_apply_timeout got none exp apply k=%0d", k);
                req = 2'b00;
                return;
            end
            checks++;
            if (owner !== exp_owner || stk_in !== ((exp_owner == 3'd1) ? 16'd200 : 16'd100)) begin
                errors++;
                $display("FAIL b2b_grant got owner=%0d in=%0d exp owner=%0d k=%0d",
                         owner, stk_in, exp_owner, k);
            end
            if (k > 0) begin
                checks++;
                if (cyc - last_apply != 3) begin
                    errors++;
                    $display("FAIL b2b_spacing got=%0d exp=3", cyc - last_apply);
                end
            end
            last_apply = cyc;
            head = 16'h0B00 + 16'(k);
            resp_head = head;
            exp_q.push_back({1'b0, exp_owner, head});
            wait_done(ok);
            if (k == 3) req = 2'b00;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL b2b_done_timeout got none exp done k=%0d", k);
                req = 2'b00;
                return;
            end
            e = exp_q.pop_front();
            checks++;
            if (done !== (2'b01 << e[W+2:W]) || {|err, owner, rdata} !== e) begin
                errors++;
                $display("FAIL b2b_result got done=%b res=%h exp res=%h", done, {|err, owner, rdata}, e);
            end
            m_ptr = (exp_owner == 3'd1) ? 0 : 1;
        end
    endtask

    task automatic test_lock();
        bit ok;
        logic [W+3:0] e;
        logic [W-1:0] head;
        resp_dly = 1;
        op_bus   = {4'h9, 4'h1};
        data_bus = {16'd300, 16'd50};
        lock     = 2'b10;
        req      = 2'b10;
        for (int k = 0; k < 4; k++) begin
            wait_apply(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL lock_apply_timeout got none exp apply k=%0d", k);
                req = 2'b00;
                lock = 2'b00;
                return;
            end
            checks++;
            if (owner !== ((k < 3) ? 3'd1 : 3'd0)) begin
                errors++;
                $display("FAIL lock_grant got owner=%0d exp=%0d k=%0d", owner, (k < 3) ? 1 : 0, k);
            end
            if (k == 0) req = 2'b11;
            head = 16'h0C00 + 16'(k);
            resp_head = head;
            exp_q.push_back({1'b0, (k < 3) ? 3'd1 : 3'd0, head});
            wait_done(ok);
            if (k == 2) begin
                lock = 2'b00;
                req  = 2'b01;
            end
            if (k == 3) req = 2'b00;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL lock_done_timeout got none exp done k=%0d", k);
                req = 2'b00;
                return;
            end
            e = exp_q.pop_front();
            checks++;
            if (done !== (2'b01 << e[W+2:W]) || {|err, owner, rdata} !== e) begin
                errors++;
                $display("FAIL lock_result got done=%b res=%h exp res=%h", done, {|err, owner, rdata}, e);
            end
        end
        m_ptr = 1;
    endtask

    task automatic test_timeout();
        bit ok;
        int a;
        logic [W+3:0] e;
        resp_dly = 0;
        req = 2'b01;
        wait_apply(ok);
        a = cyc;
        exp_q.push_back({1'b1, 3'd0, 16'd0});
        wait_done(ok);
        req = 2'b00;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL timeout_done got none exp done");
            return;
        end
        checks++;
        if (cyc - a != TIMEOUT + 1) begin
            errors++;
            $display("FAIL timeout_latency got=%0d exp=%0d", cyc - a, TIMEOUT + 1);
        end
        e = exp_q.pop_front();
        checks++;
        if (done !== 2'b01 || err !== 2'b01 || {|err, owner, rdata} !== e) begin
            errors++;
            $display("FAIL timeout_result got done=%b err=%b res=%h exp 01 01 %h",
                     done, err, {|err, owner, rdata}, e);
        end
        next_cycle();
        checks++;
        if (dbg_state !== S_IDLE || err !== 2'b00) begin
            errors++;
            $display("FAIL timeout_idle got state=%0d err=%b exp 0 00", dbg_state, err);
        end
        m_ptr = 1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [W+3:0] e;
        resp_dly = 0;
        req = 2'b11;
        wait_apply(ok);
        checks++;
        if (owner !== 3'(m_ptr)) begin
            errors++;
            $display("FAIL rstmid_grant got owner=%0d exp=%0d", owner, m_ptr);
        end
        next_cycle();
        next_cycle();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({done, err, rdata, owner, stk_op, stk_in, stk_apply, busy} !== '0 || dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL rstmid_async got=%h state=%0d exp=0 0",
                     {done, err, rdata, owner, stk_op, stk_in, stk_apply, busy}, dbg_state);
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            checks++;
            if (done !== 2'b00 || stk_apply !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_quiet got done=%b apply=%b exp 00 0", done, stk_apply);
            end
        end
        rst = 1'b1;
        m_ptr = 0;
        resp_dly = 1;
        wait_apply(ok);
        checks++;
        if (!ok || owner !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_regrant got ok=%b owner=%0d exp 1 0", ok, owner);
        end
        resp_head = 16'h0D0D;
        exp_q.push_back({1'b0, 3'd0, 16'h0D0D});
        wait_done(ok);
        req = 2'b00;
        if (ok) begin
            e = exp_q.pop_front();
            checks++;
            if (done !== 2'b01 || {|err, owner, rdata} !== e) begin
                errors++;
                $display("FAIL rstmid_result got done=%b res=%h exp res=%h", done, {|err, owner, rdata}, e);
            end
        end else begin
            checks++;
            errors++;
            $display("FAIL rstmid_done_timeout got none exp done");
        end
        m_ptr = 1;
    endtask

    task automatic test_drop_req();
        bit ok;
        int applies;
        logic [W+3:0] e;
        resp_dly  = 1;
        resp_head = 16'd13;
        op_bus    = {4'h0, 4'h2};
        data_bus  = {16'd0, 16'd777};
        req       = 2'b01;
        exp_q.push_back({1'b0, 3'd0, 16'd13});
        next_cycle();
        checks++;
        if (stk_apply !== 1'b1 || owner !== 3'd0) begin
            errors++;
            $display("FAIL drop_issue got apply=%b owner=%0d exp 1 0", stk_apply, owner);
        end
        req      = 2'b00;
        op_bus   = {4'h0, 4'hF};
        data_bus = {16'd0, 16'd999};
        next_cycle();
        checks++;
        if (stk_in !== 16'd777 || stk_op !== 4'h2) begin
            errors++;
            $display("FAIL drop_operand got in=%0d op=%h exp 777 2", stk_in, stk_op);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drop_done_timeout got none exp done");
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (done !== 2'b01 || {|err, owner, rdata} !== e) begin
                errors++;
                $display("FAIL drop_result got done=%b res=%h exp res=%h", done, {|err, owner, rdata}, e);
            end
        end
        applies = 0;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            if (stk_apply) applies++;
        end
        checks++;
        if (applies != 0 || rdata !== 16'd13) begin
            errors++;
            $display("FAIL drop_no_regrant got applies=%0d rdata=%0d exp 0 13", applies, rdata);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_lock();
        test_timeout();
        test_reset_mid();
        test_drop_req();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
